// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   DIGIT_W     : width of one packed BCD digit
//   ADD3_THRESH : digit value at or above which double-dabble adds 3
//   state_t     : converter FSM states
//   cnt_width() : width of a counter that must hold the value BIN_W
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction, purely combinational.
//   digit_in  : 4-bit BCD digit before the shift
//   digit_out : digit_in + 3 when digit_in >= 5, otherwise digit_in
//               (4-bit result, carry discarded)
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADD3_THRESH) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds packed BCD operands to the downstream combinational BCD adders.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : conversion request, bin sampled on the same edge
//   bin      : binary operand (BIN_W bits)
//   busy     : high while shifting
//   done     : one-cycle pulse when out/overflow have been updated
//   out      : packed BCD result, digit 0 in out[3:0]
//   overflow : result did not fit in DIGITS digits
//   sign     : only with BIN2BCD_SIGNED_EN; bin is two's complement,
//              out holds |bin| and sign holds the input sign bit
// Optional feature macro: BIN2BCD_SIGNED_EN
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] out,
    output logic                      overflow
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                      sign
`endif
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    state_t state, state_nxt;

    logic [BIN_W-1:0] bin_shift;
    logic [BIN_W-1:0] bin_mag;
    logic [BCD_W-1:0] bcd_work;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_shifted;
    logic [CNT_W-1:0] cnt;
    logic             ovf_work;
    logic             ovf_bit;
    logic             load;
    logic             last_shift;
`ifdef BIN2BCD_SIGNED_EN
    logic             sign_work;
`endif

    // Add-3 correction on every digit before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_in  (bcd_work[g*DIGIT_W +: DIGIT_W]),
            .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Magnitude is taken as an unsigned BIN_W-bit value so that the most
    // negative input (-2^(BIN_W-1)) maps to 2^(BIN_W-1) without overflow.
    always_comb begin
`ifdef BIN2BCD_SIGNED_EN
        bin_mag = bin[BIN_W-1] ? (~bin) + BIN_W'(1) : bin;
`else
        bin_mag = bin;
`endif
    end

    always_comb begin
        bcd_shifted = {bcd_adj[BCD_W-2:0], bin_shift[BIN_W-1]};
        ovf_bit     = bcd_adj[BCD_W-1];
        load        = start && ((state == IDLE) || (state == DONE));
        last_shift  = (state == SHIFT) && (cnt == CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // Datapath. On the final shift the just-shifted value and overflow bit
    // go straight to the result registers, so out is valid as DONE begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_shift <= '0;
            bcd_work  <= '0;
            cnt       <= '0;
            ovf_work  <= 1'b0;
            out       <= '0;
            overflow  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_work <= 1'b0;
            sign      <= 1'b0;
`endif
        end else if (load) begin
            bin_shift <= bin_mag;
            bcd_work  <= '0;
            cnt       <= CNT_W'(BIN_W);
            ovf_work  <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_work <= bin[BIN_W-1];
`endif
        end else if (state == SHIFT) begin
            bin_shift <= {bin_shift[BIN_W-2:0], 1'b0};
            bcd_work  <= bcd_shifted;
            cnt       <= cnt - 1'b1;
            ovf_work  <= ovf_work | ovf_bit;
            if (last_shift) begin
                out      <= bcd_shifted;
                overflow <= ovf_work | ovf_bit;
`ifdef BIN2BCD_SIGNED_EN
                sign     <= sign_work;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq. Two instances (3 digits and 2 digits)
// share the same stimulus; expected results come from decimal arithmetic.
// Honours BIN2BCD_SIGNED_EN when defined.
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin   = '0;

    logic        busy3, done3, ovf3;
    logic [11:0] out3;
    logic        busy2, done2, ovf2;
    logic [7:0]  out2;
`ifdef BIN2BCD_SIGNED_EN
    logic        sign3, sign2;
`endif

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy3),
        .done     (done3),
        .out      (out3),
        .overflow (ovf3)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .sign     (sign3)
`endif
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy2),
        .done     (done2),
        .out      (out2),
        .overflow (ovf2)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .sign     (sign2)
`endif
    );

    typedef struct {
        logic [11:0] out3;
        logic [7:0]  out2;
        logic        ov3;
        logic        ov2;
        logic        sgn;
        int unsigned due;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int unsigned v);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [7:0] b, input int unsigned due);
        exp_t        e;
        int unsigned mag;
        logic [11:0] b2;
`ifdef BIN2BCD_SIGNED_EN
        e.sgn = b[7];
        mag   = b[7] ? 256 - int'(b) : int'(b);
`else
        e.sgn = 1'b0;
        mag   = b;
`endif
        e.out3 = to_bcd(mag % 1000);
        e.ov3  = (mag >= 1000);
        b2     = to_bcd(mag % 100);
        e.out2 = b2[7:0];
        e.ov2  = (mag >= 100);
        e.due  = due;
        return e;
    endfunction

    // Monitor: samples on the falling edge, drivers act 1 time unit later.
    logic [11:0] held3 = '0;
    logic [7:0]  held2 = '0;

    always @(negedge clk) begin
        exp_t e;
        logic eb;
        if (!rst_n) begin
            held3 = '0;
            held2 = '0;
        end else begin
            eb = (q.size() > 0) && (cyc + BIN_W >= q[0].due) && (cyc < q[0].due);
            check("busy", {busy3, busy2}, {eb, eb});
            if (done3 || done2) begin
                if (q.size() == 0) begin
                    check("spurious_done", {done3, done2}, 2'b00);
                end else begin
                    e = q.pop_front();
                    check("done_pair", {done3, done2}, 2'b11);
                    check("latency", cyc, e.due);
                    check("out", out3, e.out3);
                    check("overflow", ovf3, e.ov3);
                    check("out_2dig", out2, e.out2);
                    check("overflow_2dig", ovf2, e.ov2);
`ifdef BIN2BCD_SIGNED_EN
                    check("sign", {sign3, sign2}, {e.sgn, e.sgn});
`endif
                    held3 = out3;
                    held2 = out2;
                end
            end else begin
                check("out_hold", {out3, out2}, {held3, held2});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drive start for one cycle; a start seen while busy is not queued.
    task automatic issue(input logic [7:0] v);
        if (!busy3) q.push_back(model(v, cyc + 1 + BIN_W));
        start = 1'b1;
        bin   = v;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            seen = done3;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: done=0 expected 1");
            q.delete();
        end
    endtask

    initial begin
        #1;
        check("reset_outputs", {busy3, done3, ovf3, out3}, '0);
        check("reset_outputs_2dig", {busy2, done2, ovf2, out2}, '0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Directed cases
        issue(8'd255); wait_idle(); step();
        issue(8'd0);   wait_idle(); step();
        issue(8'd99);  wait_idle(); step();
        issue(8'd100); wait_idle(); step();

        // Start while busy is ignored
        issue(8'd200); step(); issue(8'd7); wait_idle(); step(); step();

        // Reset mid-conversion
        issue(8'd123); step(); step();
        rst_n = 1'b0;
        q.delete();
        #1;
        check("abort_state", {busy3, done3, ovf3, out3}, '0);
        check("abort_state_2dig", {busy2, done2, ovf2, out2}, '0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        issue(8'd123); wait_idle(); step();

        // Overflow on 2-digit instance, then back-to-back start in DONE
        issue(8'd200); wait_done(); issue(8'd42); wait_idle(); step();

`ifdef BIN2BCD_SIGNED_EN
        issue(8'h80); wait_idle(); step();
        issue(8'hFF); wait_idle(); step();
        issue(8'h81); wait_idle(); step();
`endif

        // Random traffic with random gaps (some starts land while busy)
        for (int i = 0; i < 60; i++) begin
            issue(8'($urandom_range(0, 255)));
            for (int g = $urandom_range(0, 10); g > 0; g--) step();
        end
        wait_idle();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
